btb_assoc: RTL and testbench



---
 rtl/btb_assoc.sv | 200 ++++++++++++++++++++
 tb/tb_btb_assoc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and
// ID/EX prediction tracking. Optional statistics counters: define BTB_STATS_EN.
module btb_assoc #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned CNT_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        found_IF,
  output logic [31:0] NPC_predicted_IF,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_EX,
  input  logic [31:0] PC_EX,
  input  logic [2:0]  branch_EX,
  input  logic        br_EX,
  input  logic [31:0] branch_target_EX,
  output logic        fail,
  output logic [31:0] NPC_correct_EX,
  output logic [31:0] lookups_o,
  output logic [31:0] hits_o,
  output logic [31:0] mispred_o
);

  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [2:0] NOBRANCH = 3'd0;

  typedef struct packed {
    logic                hit;
    logic [WAY_BITS-1:0] way;
    logic                taken;
    logic [31:0]         target;
  } pred_t;

  logic [WAYS-1:0]     valid_q  [SETS];
  logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
  logic [31:0]         target_q [SETS][WAYS];
  logic [CNT_BITS-1:0] cnt_q    [SETS][WAYS];
  logic [WAY_BITS-1:0] victim_q [SETS];

  logic [INDEX_BITS-1:0] idx_if;
  logic [TAG_BITS-1:0]   tag_if;
  logic                  hit_if;
  logic [WAY_BITS-1:0]   way_if;
  logic                  taken_if;
  pred_t                 if_rec;
  pred_t                 id_q;
  pred_t                 ex_q;

  logic [INDEX_BITS-1:0] idx_ex;
  logic [TAG_BITS-1:0]   tag_ex;
  logic                  is_branch;
  logic                  update_en;
  logic                  have_free;
  logic [WAY_BITS-1:0]   free_way;
  logic [WAY_BITS-1:0]   alloc_way;
  logic [WAY_BITS-1:0]   victim_next;
  logic                  unused_pc_lsbs;

  assign unused_pc_lsbs = ^{PC_IF[1:0], PC_EX[1:0]};

  assign idx_if = PC_IF[INDEX_BITS+1:2];
  assign tag_if = PC_IF[31:INDEX_BITS+2];

  // Lowest matching way wins should a tag ever be present twice in a set.
  always_comb begin
    hit_if = 1'b0;
    way_if = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_if && valid_q[idx_if][w] && (tag_q[idx_if][w] == tag_if)) begin
        hit_if = 1'b1;
        way_if = WAY_BITS'(w);
      end
    end
  end

  assign taken_if         = hit_if && cnt_q[idx_if][way_if][CNT_BITS-1];
  assign found_IF         = hit_if;
  assign NPC_predicted_IF = taken_if ? target_q[idx_if][way_if] : PC_IF + 32'd4;

  always_comb begin
    if_rec        = '0;
    if_rec.hit    = hit_if;
    if_rec.way    = way_if;
    if_rec.taken  = taken_if;
    if_rec.target = target_q[idx_if][way_if];
  end

  // Stall freezes both trackers and outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= flush ? '0 : id_q;
      id_q <= if_rec;
    end
  end

  assign is_branch = (branch_EX != NOBRANCH);

  always_comb begin
    fail = 1'b0;
    if (valid_EX) begin
      if (is_branch)
        fail = (br_EX != ex_q.taken) ||
               (br_EX && ex_q.taken && (ex_q.target != branch_target_EX));
      else
        fail = ex_q.taken;
    end
  end

  assign NPC_correct_EX = br_EX ? branch_target_EX : PC_EX + 32'd4;

  assign idx_ex    = PC_EX[INDEX_BITS+1:2];
  assign tag_ex    = PC_EX[31:INDEX_BITS+2];
  assign update_en = valid_EX && !stall;

  always_comb begin
    have_free = 1'b0;
    free_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!have_free && !valid_q[idx_ex][w]) begin
        have_free = 1'b1;
        free_way  = WAY_BITS'(w);
      end
    end
  end

  assign alloc_way   = have_free ? free_way : victim_q[idx_ex];
  assign victim_next = (WAYS == 1) ? '0 : victim_q[idx_ex] + WAY_BITS'(1);

  // Tags and targets are left untouched by reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++)
          cnt_q[s][w] <= '0;
      end
    end else if (update_en) begin
      if (ex_q.hit) begin
        if (is_branch) begin
          if (br_EX) begin
            if (cnt_q[idx_ex][ex_q.way] != '1)
              cnt_q[idx_ex][ex_q.way] <= cnt_q[idx_ex][ex_q.way] + CNT_BITS'(1);
            target_q[idx_ex][ex_q.way] <= branch_target_EX;
          end else if (cnt_q[idx_ex][ex_q.way] != '0) begin
            cnt_q[idx_ex][ex_q.way] <= cnt_q[idx_ex][ex_q.way] - CNT_BITS'(1);
          end
        end else begin
          valid_q[idx_ex][ex_q.way] <= 1'b0;
        end
      end else if (br_EX) begin
        valid_q[idx_ex][alloc_way]  <= 1'b1;
        tag_q[idx_ex][alloc_way]    <= tag_ex;
        target_q[idx_ex][alloc_way] <= branch_target_EX;
        cnt_q[idx_ex][alloc_way]    <= CNT_INIT;
        if (!have_free)
          victim_q[idx_ex] <= victim_next;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] hits_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (!stall)
        lookups_q <= lookups_q + 32'd1;
      if (!stall && found_IF)
        hits_q <= hits_q + 32'd1;
      if (fail)
        mispred_q <= mispred_q + 32'd1;
    end
  end

  assign lookups_o = lookups_q;
  assign hits_o    = hits_q;
  assign mispred_o = mispred_q;
`else
  assign lookups_o = '0;
  assign hits_o    = '0;
  assign mispred_o = '0;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios then randomized traffic
// compared against a behavioural table model.
module tb_btb_assoc;

  localparam int IB = 4;
  localparam int NW = 2;
  localparam int CB = 2;
  localparam int NS = 1 << IB;
  localparam int CMAX = (1 << CB) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_IF = '0;
  logic        found_IF;
  logic [31:0] NPC_predicted_IF;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_EX = 1'b0;
  logic [31:0] PC_EX = '0;
  logic [2:0]  branch_EX = '0;
  logic        br_EX = 1'b0;
  logic [31:0] branch_target_EX = '0;
  logic        fail;
  logic [31:0] NPC_correct_EX;
  logic [31:0] lookups_o;
  logic [31:0] hits_o;
  logic [31:0] mispred_o;

  always #5 clk = ~clk;

  btb_assoc #(
    .INDEX_BITS(IB),
    .WAYS(NW),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PC_IF(PC_IF),
    .found_IF(found_IF),
    .NPC_predicted_IF(NPC_predicted_IF),
    .stall(stall),
    .flush(flush),
    .valid_EX(valid_EX),
    .PC_EX(PC_EX),
    .branch_EX(branch_EX),
    .br_EX(br_EX),
    .branch_target_EX(branch_target_EX),
    .fail(fail),
    .NPC_correct_EX(NPC_correct_EX),
    .lookups_o(lookups_o),
    .hits_o(hits_o),
    .mispred_o(mispred_o)
  );

  typedef struct packed {
    logic        hit;
    logic [2:0]  way;
    logic        taken;
    logic [31:0] tgt;
  } rec_t;

  bit          mv   [NS][NW];
  logic [25:0] mt   [NS][NW];
  logic [31:0] mg   [NS][NW];
  int          mc   [NS][NW];
  int          mvic [NS];
  rec_t        m_id;
  rec_t        m_ex;
  logic [31:0] m_look;
  logic [31:0] m_hits;
  logic [31:0] m_mis;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t m_lookup(input logic [31:0] pc);
    rec_t r;
    int   s;
    r = '0;
    s = int'(pc[5:2]);
    for (int w = 0; w < NW; w++) begin
      if (!r.hit && mv[s][w] && mt[s][w] == pc[31:6]) begin
        r.hit   = 1'b1;
        r.way   = 3'(w);
        r.taken = (mc[s][w] >= (1 << (CB - 1)));
        r.tgt   = mg[s][w];
      end
    end
    return r;
  endfunction

  function automatic logic m_fail();
    if (!valid_EX) return 1'b0;
    if (branch_EX != 3'd0)
      return (br_EX != m_ex.taken) || (br_EX && m_ex.taken && m_ex.tgt != branch_target_EX);
    return m_ex.taken;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < NS; s++) begin
      mvic[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        mc[s][w] = 0;
      end
    end
    m_id = '0;
    m_ex = '0;
    m_look = '0;
    m_hits = '0;
    m_mis = '0;
  endtask

  // Apply one clock's worth of model state change from the currently driven inputs.
  task automatic tick();
    rec_t r;
    logic f;
    int   s;
    int   w;
    r = m_lookup(PC_IF);
    f = m_fail();
    if (rst) begin
      m_clear();
    end else begin
      if (!stall) begin
        m_look++;
        if (r.hit) m_hits++;
      end
      if (f) m_mis++;
      if (valid_EX && !stall) begin
        s = int'(PC_EX[5:2]);
        if (m_ex.hit) begin
          w = int'(m_ex.way);
          if (branch_EX != 3'd0) begin
            if (br_EX) begin
              if (mc[s][w] < CMAX) mc[s][w]++;
              mg[s][w] = branch_target_EX;
            end else if (mc[s][w] > 0) begin
              mc[s][w]--;
            end
          end else begin
            mv[s][w] = 1'b0;
          end
        end else if (br_EX) begin
          w = -1;
          for (int i = 0; i < NW; i++)
            if (w < 0 && !mv[s][i]) w = i;
          if (w < 0) begin
            w = mvic[s];
            mvic[s] = (mvic[s] + 1) % NW;
          end
          mv[s][w] = 1'b1;
          mt[s][w] = PC_EX[31:6];
          mg[s][w] = branch_target_EX;
          mc[s][w] = 1 << (CB - 1);
        end
      end
      if (!stall) begin
        m_ex = flush ? '0 : m_id;
        m_id = r;
      end
    end
    @(posedge clk);
  endtask

  task automatic drive(input logic st, input logic fl, input logic [31:0] pif,
                       input logic ve, input logic [31:0] pex, input logic [2:0] bt,
                       input logic b, input logic [31:0] tg);
    rec_t r;
    @(negedge clk);
    stall = st;
    flush = fl;
    PC_IF = pif;
    valid_EX = ve;
    PC_EX = pex;
    branch_EX = bt;
    br_EX = b;
    branch_target_EX = tg;
    #1;
    if (!rst) begin
      r = m_lookup(PC_IF);
      check("found_IF", {31'd0, found_IF}, {31'd0, r.hit});
      check("NPC_predicted_IF", NPC_predicted_IF, r.taken ? r.tgt : PC_IF + 32'd4);
      check("fail", {31'd0, fail}, {31'd0, m_fail()});
      check("NPC_correct_EX", NPC_correct_EX, br_EX ? branch_target_EX : PC_EX + 32'd4);
`ifdef BTB_STATS_EN
      check("lookups_o", lookups_o, m_look);
      check("hits_o", hits_o, m_hits);
      check("mispred_o", mispred_o, m_mis);
`else
      check("stats_zero", lookups_o | hits_o | mispred_o, 32'd0);
`endif
    end
  endtask

  task automatic ifc(input logic [31:0] pif);
    drive(1'b0, 1'b0, pif, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
  endtask

  task automatic step_if(input logic [31:0] pif);
    ifc(pif);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] pc_id;
  logic [31:0] pc_ex;
  logic        v_id;
  logic        v_ex;

  initial begin
    m_clear();
    do_reset();

    // Scenario 1: empty table after reset
    ifc(32'h100);
    check("s1_found", {31'd0, found_IF}, 32'd0);
    check("s1_npc", NPC_predicted_IF, 32'h104);
    tick();

    // Scenario 2: first taken branch allocates
    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 3'd1, 1'b1, 32'h80);
    check("s2_fail", {31'd0, fail}, 32'd1);
    check("s2_npcc", NPC_correct_EX, 32'h80);
    tick();
    ifc(32'h100);
    check("s2_found", {31'd0, found_IF}, 32'd1);
    check("s2_npc", NPC_predicted_IF, 32'h80);
    tick();

    // Scenario 3: counter saturates at zero
    step_if(32'h100);
    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 3'd1, 1'b0, 32'h80);
    tick();
    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 3'd1, 1'b0, 32'h80);
    tick();
    ifc(32'h100);
    check("s3_found", {31'd0, found_IF}, 32'd1);
    check("s3_npc", NPC_predicted_IF, 32'h104);
    tick();
    drive(1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 3'd1, 1'b0, 32'h80);
    check("s3_fail_nt", {31'd0, fail}, 32'd0);
    tick();
    ifc(32'h100);
    check("s3_sat_npc", NPC_predicted_IF, 32'h104);
    tick();

    // Scenario 4: third allocation into set 0 evicts way 0
    step_if(32'h200);
    step_if(32'h200);
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h140, 3'd1, 1'b1, 32'h1000);
    tick();
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h180, 3'd1, 1'b1, 32'h2000);
    tick();
    ifc(32'h100);
    check("s4_100", {31'd0, found_IF}, 32'd0);
    tick();
    ifc(32'h140);
    check("s4_140", {31'd0, found_IF}, 32'd1);
    tick();
    ifc(32'h180);
    check("s4_180", {31'd0, found_IF}, 32'd1);
    tick();

    // Scenario 5: taken hit resolved as a non-branch invalidates the entry
    step_if(32'h200);
    step_if(32'h200);
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h100, 3'd1, 1'b1, 32'h80);
    tick();
    step_if(32'h100);
    step_if(32'h200);
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h100, 3'd0, 1'b0, 32'h0);
    check("s5_fail", {31'd0, fail}, 32'd1);
    check("s5_npcc", NPC_correct_EX, 32'h104);
    tick();
    ifc(32'h100);
    check("s5_found", {31'd0, found_IF}, 32'd0);
    tick();

    // Scenario 6: stall holds EX, flush clears it
    step_if(32'h200);
    step_if(32'h200);
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h100, 3'd1, 1'b1, 32'h80);
    tick();
    step_if(32'h200);
    step_if(32'h100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h300, 1'b1, 32'h100, 3'd1, 1'b0, 32'h80);
      check("s6_stall_fail", {31'd0, fail}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h200, 1'b1, 32'h100, 3'd1, 1'b0, 32'h80);
    check("s6_flush_fail", {31'd0, fail}, 32'd0);
    tick();

    // Randomized traffic with PCs flowing IF -> ID -> EX
    pc_id = '0; pc_ex = '0; v_id = 1'b0; v_ex = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        st;
      logic        fl;
      logic [31:0] pif;
      logic [31:0] pex;
      logic [2:0]  bt;
      logic        b;
      logic [31:0] tg;
      if (i == 1500) begin
        do_reset();
        pc_id = '0; pc_ex = '0; v_id = 1'b0; v_ex = 1'b0;
      end
      st  = ($urandom_range(0, 99) < 15);
      fl  = ($urandom_range(0, 99) < 10);
      pif = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
      pex = pc_ex;
      if ($urandom_range(0, 9) == 0)
        pex = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
      bt  = ($urandom_range(0, 99) < 30) ? 3'd0 : 3'($urandom_range(1, 7));
      b   = (bt == 3'd0) ? ($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1));
      tg  = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      drive(st, fl, pif, v_ex, pex, bt, b, tg);
      tick();
      if (!st) begin
        v_ex  = fl ? 1'b0 : v_id;
        pc_ex = pc_id;
        v_id  = 1'b1;
        pc_id = pif;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
